fft_mem_pp: RTL
===============

Name: fft_mem_pp

Overview:
Parametrised ping-pong successor of the FFT 8x8 register manager. It holds two NxN banks:
- Compute bank: accessed by the FFT core through the 1xN row/column port, for in-place 2-D passes with transpose.
- Fill bank: accessed by the loader/unloader through the 1x1 port, which loads new samples and drains the previous results.
A swap handshake exchanges the roles of the two banks. Load/drain of frame n+1 overlaps compute of frame n.

Parameters:
DATA_WD, 10, width of one sample
SIZE_MAT_WD, 3, log2 of matrix dimension; N = 2**SIZE_MAT_WD, bank depth N*N

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dim_sel_i  in  1  0: row, 1: column, for the 1xN port
adr_1xn_i  in  SIZE_MAT_WD  row/column index
rd_vld_1xn_i  in  1  1xN read request (compute bank)
rd_vld_1xn_o  out  1  1xN read data valid
rd_dat_1xn_o  out  N*DATA_WD  1xN read data
wr_vld_1xn_i  in  1  1xN write (compute bank)
wr_dat_1xn_i  in  N*DATA_WD  1xN write data
adr_1x1_i  in  2*SIZE_MAT_WD  element address (row*N+col)
rd_vld_1x1_i  in  1  1x1 read request (fill bank)
rd_vld_1x1_o  out  1  1x1 read data valid
rd_dat_1x1_o  out  DATA_WD  1x1 read data
wr_vld_1x1_i  in  1  1x1 write (fill bank)
wr_dat_1x1_i  in  DATA_WD  1x1 write data
swap_req_i  in  1  request bank swap (pulse or level)
swap_ack_o  out  1  one-cycle pulse when a swap has taken effect
ready_o  out  1  fill bank fully written since last swap
bank_o  out  1  index of the current compute bank

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: rd_vld_* 0; rd_dat_* 0; swap_ack_o 0; ready_o 0; bank_o 0; fill counter 0; pending flag 0. Bank contents are not reset; reads of never-written locations are undefined.
- Bank mapping:
  - compute bank = bank_o; fill bank = ~bank_o.
  - 1xN port only touches the compute bank; 1x1 port only touches the fill bank.
  - The two ports never conflict.
- 1xN lane packing: element k is at bits [k*DATA_WD +: DATA_WD].
  - Row a: lane k ↔ address a*N+k.
  - Column a: lane k ↔ address k*N+a.
- Read latency is 1 cycle on both ports.
  - rd_vld_*_o equals rd_vld_*_i delayed by one cycle.
  - rd_dat_*_o holds its last value when no read is issued.
- Read and write on the same port in the same cycle are both performed, using one shared address/dim_sel. The read returns the pre-write contents: the unloader drains result (addr) while the loader writes new sample (addr) in the same cycle.
- Fill counter:
  - Counts 1x1 writes, 0..N*N, saturating at N*N.
  - ready_o = (count == N*N), registered, asserted the cycle after the N*N-th write.
  - Rewrites of an address still count; the counter is an occupancy counter, not a coverage check.
- Swap FSM with states IDLE and PEND:
  - IDLE, swap_req_i=1, ready_o=1: swap at this edge.
  - IDLE, swap_req_i=1, ready_o=0: go to PEND.
  - PEND: swap at the first edge with ready_o=1, then return to IDLE. Further requests while in PEND are absorbed.
- Swap effects (at the swap edge):
  - bank_o toggles and the fill counter clears to 0.
  - ready_o=0 and swap_ack_o=1 for exactly one cycle, both in the cycle after the swap edge.
  - Accesses issued in the swap cycle use the old mapping. Their read data returns from the old bank one cycle later.
- A 1x1 write in the same cycle as the swap edge lands in the old fill bank and is not counted toward the new frame.
- Reset mid-operation: PEND is dropped, the counter clears, bank_o returns to 0, and contents are retained.

Decomposition:
- Package fft_mem_pkg: SIZE_MAT = 1<<SIZE_MAT_WD, SIZE_MAT_FUL = SIZE_MAT*SIZE_MAT, SIZE_MAT_FUL_WD, swap FSM state encoding (IDLE=0, PEND=1).
- Sub-module fft_mem_bank: one NxN register bank with a 1xN row/column port and a 1x1 port, combinational read, write enable. Instantiated twice.
- The top holds the muxing, output registers, fill counter and swap FSM.

Test Plan:
1. Assert rst for 2 cycles, then release -> all outputs 0, bank_o=0, ready_o=0.
2. Write 64 1x1 values data=addr (N=8), then pulse swap_req_i -> ready_o=1 after the 64th write. Next cycle: bank_o=1, swap_ack_o high for 1 cycle. Row read adr 2 returns lanes 16..23; column read adr 3 returns 3,11,19,...,59.
3. Pulse swap_req_i after 10 writes -> no ack; FSM stays in PEND. Ack arrives the cycle after ready_o rises following the 64th write.
4. Issue 1x1 rd+wr at addr 5 with wr data 0x155 over old value 0x005 -> rd_dat_1x1_o=0x005; a subsequent read returns 0x155.
5. Column write adr 1 with lanes 0..7 = 0x100+k, then row read adr k -> lane 1 = 0x100+k. A 1x1 read of addr 9 returns fill-bank data, not 0x101.
6. Assert rst while in PEND with count=30 -> bank_o=0, ready_o=0, no ack. After re-fill, compute-bank contents are unchanged.

Source files
------------

// File: rtl/fft_mem_pp_pkg.sv
// ---------------------------------------------------------------------------
// fft_mem_pkg : shared sizing helpers and swap FSM encoding for fft_mem_pp
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_mem_pkg;

  localparam int DATA_WD_DFLT     = 10;
  localparam int SIZE_MAT_WD_DFLT = 3;

  function automatic int size_mat(input int wd);
    return 1 << wd;
  endfunction

  function automatic int size_mat_ful(input int wd);
    return size_mat(wd) * size_mat(wd);
  endfunction

  // One extra bit so the counter can hold the full value N*N.
  function automatic int size_mat_ful_wd(input int wd);
    return 2 * wd + 1;
  endfunction

  localparam int SIZE_MAT        = size_mat(SIZE_MAT_WD_DFLT);
  localparam int SIZE_MAT_FUL    = size_mat_ful(SIZE_MAT_WD_DFLT);
  localparam int SIZE_MAT_FUL_WD = size_mat_ful_wd(SIZE_MAT_WD_DFLT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } swap_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_mem_pp_if.sv
// ---------------------------------------------------------------------------
// fft_mem_pp_if : 1xN compute port, 1x1 fill port and swap handshake
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fft_mem_pp_if #(
  parameter int DATA_WD     = 10,
  parameter int SIZE_MAT_WD = 3
);
  localparam int N = 1 << SIZE_MAT_WD;

  logic                     dim_sel_i;
  logic [SIZE_MAT_WD-1:0]   adr_1xn_i;
  logic                     rd_vld_1xn_i;
  logic                     rd_vld_1xn_o;
  logic [N*DATA_WD-1:0]     rd_dat_1xn_o;
  logic                     wr_vld_1xn_i;
  logic [N*DATA_WD-1:0]     wr_dat_1xn_i;
  logic [2*SIZE_MAT_WD-1:0] adr_1x1_i;
  logic                     rd_vld_1x1_i;
  logic                     rd_vld_1x1_o;
  logic [DATA_WD-1:0]       rd_dat_1x1_o;
  logic                     wr_vld_1x1_i;
  logic [DATA_WD-1:0]       wr_dat_1x1_i;
  logic                     swap_req_i;
  logic                     swap_ack_o;
  logic                     ready_o;
  logic                     bank_o;

  modport slave (
    input  dim_sel_i, adr_1xn_i, rd_vld_1xn_i, wr_vld_1xn_i, wr_dat_1xn_i,
    input  adr_1x1_i, rd_vld_1x1_i, wr_vld_1x1_i, wr_dat_1x1_i, swap_req_i,
    output rd_vld_1xn_o, rd_dat_1xn_o, rd_vld_1x1_o, rd_dat_1x1_o,
    output swap_ack_o, ready_o, bank_o
  );

  modport master (
    output dim_sel_i, adr_1xn_i, rd_vld_1xn_i, wr_vld_1xn_i, wr_dat_1xn_i,
    output adr_1x1_i, rd_vld_1x1_i, wr_vld_1x1_i, wr_dat_1x1_i, swap_req_i,
    input  rd_vld_1xn_o, rd_dat_1xn_o, rd_vld_1x1_o, rd_dat_1x1_o,
    input  swap_ack_o, ready_o, bank_o
  );

endinterface

`default_nettype wire

// File: rtl/fft_mem_pp_bank.sv
// ---------------------------------------------------------------------------
// fft_mem_bank : NxN register bank, 1xN row/column port + 1x1 port
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_mem_bank #(
  parameter int DATA_WD     = 10,
  parameter int SIZE_MAT_WD = 3
) (
  input  wire logic                               clk,
  input  wire logic                               dim_sel_i,
  input  wire logic [SIZE_MAT_WD-1:0]             adr_1xn_i,
  input  wire logic                               wr_1xn_i,
  input  wire logic [(DATA_WD<<SIZE_MAT_WD)-1:0]  wr_dat_1xn_i,
  output logic      [(DATA_WD<<SIZE_MAT_WD)-1:0]  rd_dat_1xn_o,
  input  wire logic [2*SIZE_MAT_WD-1:0]           adr_1x1_i,
  input  wire logic                               wr_1x1_i,
  input  wire logic [DATA_WD-1:0]                 wr_dat_1x1_i,
  output logic      [DATA_WD-1:0]                 rd_dat_1x1_o
);
  import fft_mem_pkg::*;

  localparam int N  = size_mat(SIZE_MAT_WD);
  localparam int NN = size_mat_ful(SIZE_MAT_WD);

  logic [DATA_WD-1:0]       mem_q [NN];
  logic [DATA_WD-1:0]       mem_d [NN];
  logic [2*SIZE_MAT_WD-1:0] lane_adr_w [N];

  // Row a lane k is {a,k}; column a lane k is {k,a}.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lane_adr_w[k] = dim_sel_i ? {SIZE_MAT_WD'(k), adr_1xn_i}
                                     : {adr_1xn_i, SIZE_MAT_WD'(k)};
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_1xn_i) begin
      for (int k = 0; k < N; k++) begin
        mem_d[lane_adr_w[k]] = wr_dat_1xn_i[k*DATA_WD +: DATA_WD];
      end
    end
    if (wr_1x1_i) begin
      mem_d[adr_1x1_i] = wr_dat_1x1_i;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_dat_1xn_o = '0;
    for (int k = 0; k < N; k++) begin
      rd_dat_1xn_o[k*DATA_WD +: DATA_WD] = mem_q[lane_adr_w[k]];
    end
  end

  assign rd_dat_1x1_o = mem_q[adr_1x1_i];

endmodule

`default_nettype wire

// File: rtl/fft_mem_pp.sv
// ---------------------------------------------------------------------------
// fft_mem_pp : ping-pong FFT matrix memory (compute bank + fill bank, swap)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_mem_pp #(
  parameter int DATA_WD     = fft_mem_pkg::DATA_WD_DFLT,
  parameter int SIZE_MAT_WD = fft_mem_pkg::SIZE_MAT_WD_DFLT
) (
  input wire logic   clk,
  input wire logic   rst,
  fft_mem_pp_if.slave bus
);
  import fft_mem_pkg::*;

  localparam int N      = size_mat(SIZE_MAT_WD);
  localparam int NN     = size_mat_ful(SIZE_MAT_WD);
  localparam int CNT_WD = size_mat_ful_wd(SIZE_MAT_WD);
  localparam logic [CNT_WD-1:0] CNT_FULL = CNT_WD'(NN);

  logic [N*DATA_WD-1:0] rd_1xn_w [2];
  logic [DATA_WD-1:0]   rd_1x1_w [2];

  swap_state_e          state_q, state_d;
  logic                 bank_q, bank_d;
  logic [CNT_WD-1:0]    cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 ack_q, ack_d;
  logic                 rd_vld_1xn_q, rd_vld_1xn_d;
  logic                 rd_vld_1x1_q, rd_vld_1x1_d;
  logic [N*DATA_WD-1:0] rd_dat_1xn_q, rd_dat_1xn_d;
  logic [DATA_WD-1:0]   rd_dat_1x1_q, rd_dat_1x1_d;
  logic                 swap_w;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_mem_bank #(
      .DATA_WD     (DATA_WD),
      .SIZE_MAT_WD (SIZE_MAT_WD)
    ) u_bank (
      .clk          (clk),
      .dim_sel_i    (bus.dim_sel_i),
      .adr_1xn_i    (bus.adr_1xn_i),
      .wr_1xn_i     (bus.wr_vld_1xn_i && (bank_q == 1'(b))),
      .wr_dat_1xn_i (bus.wr_dat_1xn_i),
      .rd_dat_1xn_o (rd_1xn_w[b]),
      .adr_1x1_i    (bus.adr_1x1_i),
      .wr_1x1_i     (bus.wr_vld_1x1_i && (bank_q != 1'(b))),
      .wr_dat_1x1_i (bus.wr_dat_1x1_i),
      .rd_dat_1x1_o (rd_1x1_w[b])
    );
  end

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    cnt_d        = cnt_q;
    ack_d        = 1'b0;
    rd_vld_1xn_d = bus.rd_vld_1xn_i;
    rd_vld_1x1_d = bus.rd_vld_1x1_i;
    rd_dat_1xn_d = bus.rd_vld_1xn_i ? rd_1xn_w[bank_q]  : rd_dat_1xn_q;
    rd_dat_1x1_d = bus.rd_vld_1x1_i ? rd_1x1_w[~bank_q] : rd_dat_1x1_q;

    swap_w = ready_q && ((state_q == ST_PEND) || bus.swap_req_i);
    if (swap_w) begin
      // A fill write in the swap cycle lands in the old bank and is not counted.
      state_d = ST_IDLE;
      bank_d  = ~bank_q;
      cnt_d   = '0;
      ack_d   = 1'b1;
    end else begin
      if ((state_q == ST_IDLE) && bus.swap_req_i) begin
        state_d = ST_PEND;
      end
      if (bus.wr_vld_1x1_i && (cnt_q != CNT_FULL)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    ready_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bank_q       <= 1'b0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      ack_q        <= 1'b0;
      rd_vld_1xn_q <= 1'b0;
      rd_vld_1x1_q <= 1'b0;
      rd_dat_1xn_q <= '0;
      rd_dat_1x1_q <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      ack_q        <= ack_d;
      rd_vld_1xn_q <= rd_vld_1xn_d;
      rd_vld_1x1_q <= rd_vld_1x1_d;
      rd_dat_1xn_q <= rd_dat_1xn_d;
      rd_dat_1x1_q <= rd_dat_1x1_d;
    end
  end

  assign bus.rd_vld_1xn_o = rd_vld_1xn_q;
  assign bus.rd_dat_1xn_o = rd_dat_1xn_q;
  assign bus.rd_vld_1x1_o = rd_vld_1x1_q;
  assign bus.rd_dat_1x1_o = rd_dat_1x1_q;
  assign bus.swap_ack_o   = ack_q;
  assign bus.ready_o      = ready_q;
  assign bus.bank_o       = bank_q;

endmodule

`default_nettype wire
